issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- Instruction queue and dispatch scheduler sitting between the fetcher and the combinational decoder.
- Buffers fetched {inst, pc, predict} entries in a circular FIFO.
- Each cycle it decides whether the head entry may be issued, based on ROB, RS and LSB occupancy, and drives the decoder's decode-enable.
- Clears itself on a branch-mispredict flush.

Parameters:
- IQ_SIZE_LOG, 4: log2 of queue depth; depth = 16 entries.
- IQ_FULL_MARGIN, 2: fetch-full is raised when free entries ≤ this margin, to cover fetcher pipeline slack.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low freezes the block
- in_fetch_valid  input  1  fetcher presents an entry this cycle
- in_fetch_inst  input  32  fetched instruction
- in_fetch_pc  input  32  instruction address
- in_fetch_predict  input  1  branch predictor taken bit
- out_fetch_full  output  1  fetcher must stop issuing new entries
- in_rob_full  input  1  ROB cannot accept an entry
- in_rs_full  input  1  reservation station cannot accept an entry
- in_lsb_full  input  1  load/store buffer cannot accept an entry
- in_flush  input  1  mispredict flush from ROB commit
- out_decode_enable  output  1  head entry is issued to decoder/ROB/RS/LSB this cycle
- out_inst  output  32  head instruction
- out_pc  output  32  head pc
- out_predict  output  1  head predict bit
- out_count  output  IQ_SIZE_LOG+1  current occupancy

Behaviour:
- Storage: arrays inst/pc/predict [0:2^IQ_SIZE_LOG-1]; registered head and tail pointers (IQ_SIZE_LOG bits, natural wrap); registered count (IQ_SIZE_LOG+1 bits).
- Reset (rst_in=1 at posedge, regardless of rdy_in): head=0, tail=0, count=0. Array contents are don't-care.
  - Resulting outputs: out_decode_enable=0, out_count=0, out_fetch_full=0. out_inst/out_pc/out_predict show entry 0 contents and are not meaningful while count=0.
- Head outputs are combinational reads of entry[head].
- Target selection, from head opcode inst[6:0]:
  - 0000011 (load) or 0100011 (store) → LSB.
  - All other opcodes → RS.
- Issue condition, combinational: out_decode_enable = rdy_in & !rst_in & !in_flush & count≠0 & !in_rob_full & (target LSB ? !in_lsb_full : !in_rs_full).
- Pop: at posedge when out_decode_enable=1, head ← head+1. Issue latency is 1 cycle from push to earliest issue, because an entry pushed at edge N is visible at the head from cycle N+1.
- Push: at posedge when rdy_in & !in_flush & in_fetch_valid & (count < 2^IQ_SIZE_LOG or a pop occurs in the same cycle). Writes the entry at tail, tail ← tail+1.
  - A push offered when the queue is full and no pop occurs is dropped silently; honouring out_fetch_full is the fetcher's contract.
- Count update: count ← count + push − pop. Simultaneous push and pop leaves count unchanged, including at count=0 (no bypass; the pushed entry issues next cycle) and at count=full.
- out_fetch_full = (2^IQ_SIZE_LOG − count) ≤ IQ_FULL_MARGIN. Combinational from registered count.
- Flush (in_flush=1 & rdy_in=1): out_decode_enable forced 0 in that cycle; next state head=0, tail=0, count=0. A push in the same cycle is discarded.
- rdy_in=0: no pointer, count or array change; out_decode_enable=0; in_flush is ignored.
  - The flush source holds in_flush until rdy_in is high.
- Priority: rst_in > !rdy_in > in_flush > normal push/pop.

Optional Feature:
- Macro IQ_STALL_STAT_EN.
- Defined: adds outputs out_stall_rob, out_stall_rs, out_stall_lsb, each 32 bits, reset to 0.
  - Each increments by 1 per rdy_in-high, non-flush cycle in which count≠0 and issue is blocked by that cause.
  - The ROB cause takes precedence, so exactly one counter increments per blocked cycle.
  - Counters wrap at 2^32 and are not cleared by in_flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then push 3 entries (pc 0x0, 0x4, 0x8, ADDI opcode 0010011), all full flags 0 → decode_enable high in the three cycles after each push; pcs issued in order 0x0, 0x4, 0x8; count returns to 0.
- Push 14 entries with no pops (in_rob_full=1) → out_fetch_full rises when count=14; count reaches 16 after 2 more pushes; a 17th push is dropped, count stays 16, and after in_rob_full=0 the entries issue in original pc order.
- Head is a load (opcode 0000011), in_lsb_full=1, in_rs_full=0 → decode_enable 0; drop in_lsb_full → issues next cycle. Repeat with an ADD (0110011) head and in_rs_full=1 → blocked.
- Count=5 and in_flush=1 with a simultaneous in_fetch_valid → decode_enable 0 that cycle; next cycle count=0, head=tail=0; the flushed-cycle push is absent.
- Count=16 with simultaneous push and pop → count stays 16; the new entry lands at the old head slot (wrap-around) and issues 16th in order.
- rdy_in=0 for 4 cycles while fetch_valid=1 and in_flush=1 → count and pointers unchanged, decode_enable 0. With IQ_STALL_STAT_EN: 3 cycles of in_rob_full=1 with count>0 → out_stall_rob=3, the others 0.

Source files
------------

// File: rtl/issue_ctrl.sv
// issue_ctrl: instruction queue + dispatch gate between fetcher and decoder.
// Optional stall counters enabled by defining IQ_STALL_STAT_EN.
module issue_ctrl #(
  parameter int IQ_SIZE_LOG    = 4,
  parameter int IQ_FULL_MARGIN = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   in_fetch_valid,
  input  logic [31:0]            in_fetch_inst,
  input  logic [31:0]            in_fetch_pc,
  input  logic                   in_fetch_predict,
  output logic                   out_fetch_full,
  input  logic                   in_rob_full,
  input  logic                   in_rs_full,
  input  logic                   in_lsb_full,
  input  logic                   in_flush,
  output logic                   out_decode_enable,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc,
  output logic                   out_predict,
  output logic [IQ_SIZE_LOG:0]   out_count
`ifdef IQ_STALL_STAT_EN
  ,
  output logic [31:0]            out_stall_rob,
  output logic [31:0]            out_stall_rs,
  output logic [31:0]            out_stall_lsb
`endif
);
  localparam int IW    = IQ_SIZE_LOG;
  localparam int CW    = IQ_SIZE_LOG + 1;
  localparam int DEPTH = 1 << IQ_SIZE_LOG;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          pred_q [DEPTH];
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          is_lsb, issue, push, flush_now, nonempty;
  assign out_inst    = inst_q[head_q];
  assign out_pc      = pc_q[head_q];
  assign out_predict = pred_q[head_q];
  assign out_count   = count_q;
  always_comb begin
    nonempty          = count_q != '0;
    is_lsb            = (out_inst[6:0] == 7'b0000011) || (out_inst[6:0] == 7'b0100011);
    issue             = rdy_in & !rst_in & !in_flush & nonempty & !in_rob_full &
                        (is_lsb ? !in_lsb_full : !in_rs_full);
    // count MSB set means exactly DEPTH entries held
    push              = rdy_in & !in_flush & in_fetch_valid & (!count_q[CW-1] | issue);
    flush_now         = rdy_in & in_flush;
    head_d            = flush_now ? '0 : head_q + IW'(issue);
    tail_d            = flush_now ? '0 : tail_q + IW'(push);
    count_d           = flush_now ? '0 : count_q + CW'(push) - CW'(issue);
    out_decode_enable = issue;
    out_fetch_full    = count_q >= CW'(DEPTH - IQ_FULL_MARGIN);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      inst_q[tail_q] <= in_fetch_inst;
      pc_q[tail_q]   <= in_fetch_pc;
      pred_q[tail_q] <= in_fetch_predict;
    end
  end
`ifdef IQ_STALL_STAT_EN
  logic [31:0] stall_rob_q, stall_rob_d, stall_rs_q, stall_rs_d, stall_lsb_q, stall_lsb_d;
  logic        blocked;
  always_comb begin
    // ROB stall wins; otherwise the blocking resource is the head's target
    blocked     = rdy_in & !in_flush & nonempty & !issue;
    stall_rob_d = stall_rob_q + 32'(blocked & in_rob_full);
    stall_rs_d  = stall_rs_q + 32'(blocked & !in_rob_full & !is_lsb);
    stall_lsb_d = stall_lsb_q + 32'(blocked & !in_rob_full & is_lsb);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_rob_q <= '0;
      stall_rs_q  <= '0;
      stall_lsb_q <= '0;
    end else begin
      stall_rob_q <= stall_rob_d;
      stall_rs_q  <= stall_rs_d;
      stall_lsb_q <= stall_lsb_d;
    end
  end
  assign out_stall_rob = stall_rob_q;
  assign out_stall_rs  = stall_rs_q;
  assign out_stall_lsb = stall_lsb_q;
`endif
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, fv, fpred, ffull, rob_full, rs_full, lsb_full, flush, de, opred;
  logic [31:0] finst, fpc, oinst, opc;
  logic [4:0]  cnt;
  int          checks = 0, failures = 0;
`ifdef IQ_STALL_STAT_EN
  logic [31:0] s_rob, s_rs, s_lsb, b_rob, b_rs, b_lsb;
`endif
  always #5 clk = ~clk;
  issue_ctrl dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .in_fetch_valid(fv), .in_fetch_inst(finst), .in_fetch_pc(fpc), .in_fetch_predict(fpred),
    .out_fetch_full(ffull), .in_rob_full(rob_full), .in_rs_full(rs_full), .in_lsb_full(lsb_full),
    .in_flush(flush), .out_decode_enable(de), .out_inst(oinst), .out_pc(opc),
    .out_predict(opred), .out_count(cnt)
`ifdef IQ_STALL_STAT_EN
    , .out_stall_rob(s_rob), .out_stall_rs(s_rs), .out_stall_lsb(s_lsb)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] pc, input logic [6:0] op);
    fv = 1'b1;
    fpc = pc;
    finst = {pc[24:0], op};
    fpred = pc[2];
  endtask
  initial begin
    rst = 1'b1; rdy = 1'b1; fv = 1'b0; finst = '0; fpc = '0; fpred = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; flush = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_count", 32'(cnt), 0);
    chk("reset_de", 32'(de), 0);
    chk("reset_full", 32'(ffull), 0);
`ifdef IQ_STALL_STAT_EN
    chk("reset_stall_rob", s_rob, 0);
    chk("reset_stall_rs", s_rs, 0);
    chk("reset_stall_lsb", s_lsb, 0);
`endif
    // three ADDI entries stream through with one-cycle latency
    push(32'h0, 7'b0010011); step();
    push(32'h4, 7'b0010011); #1;
    chk("t1_de0", 32'(de), 1); chk("t1_pc0", opc, 32'h0);
    step();
    push(32'h8, 7'b0010011); #1;
    chk("t1_de1", 32'(de), 1); chk("t1_pc1", opc, 32'h4);
    step();
    fv = 1'b0; #1;
    chk("t1_de2", 32'(de), 1); chk("t1_pc2", opc, 32'h8); chk("t1_cnt", 32'(cnt), 1);
    step();
    chk("t1_empty", 32'(cnt), 0); chk("t1_de_idle", 32'(de), 0);
    // fill to full with ROB blocked
    rob_full = 1'b1;
    for (int i = 0; i < 13; i++) begin push(32'h100 + 32'(4 * i), 7'b0010011); step(); end
    chk("t2_cnt13", 32'(cnt), 13); chk("t2_full13", 32'(ffull), 0);
    chk("t2_de_blocked", 32'(de), 0);
    push(32'h100 + 32'(4 * 13), 7'b0010011); step();
    chk("t2_cnt14", 32'(cnt), 14); chk("t2_full14", 32'(ffull), 1);
    for (int i = 14; i < 16; i++) begin push(32'h100 + 32'(4 * i), 7'b0010011); step(); end
    chk("t2_cnt16", 32'(cnt), 16);
    push(32'h1FC, 7'b0010011); step();
    chk("t2_drop_cnt", 32'(cnt), 16);
    fv = 1'b0; rob_full = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("t2_de%0d", i), 32'(de), 1);
      chk($sformatf("t2_pc%0d", i), opc, 32'h100 + 32'(4 * i));
      step();
    end
    chk("t2_empty", 32'(cnt), 0); chk("t2_full_clear", 32'(ffull), 0);
    // load head blocked by LSB, ADD head blocked by RS, store ignores RS
    lsb_full = 1'b1;
    push(32'h200, 7'b0000011); step();
    fv = 1'b0; #1;
    chk("t3_load_blocked", 32'(de), 0);
    step();
    chk("t3_load_held", 32'(cnt), 1);
    lsb_full = 1'b0; #1;
    chk("t3_load_issue", 32'(de), 1); chk("t3_load_pc", opc, 32'h200);
    step();
    rs_full = 1'b1;
    push(32'h204, 7'b0110011); step();
    fv = 1'b0; #1;
    chk("t3_add_blocked", 32'(de), 0);
    rs_full = 1'b0; #1;
    chk("t3_add_issue", 32'(de), 1);
    step();
    rs_full = 1'b1; lsb_full = 1'b0;
    push(32'h208, 7'b0100011); step();
    fv = 1'b0; #1;
    chk("t3_store_rs_full", 32'(de), 1); chk("t3_store_pc", opc, 32'h208);
    step();
    rs_full = 1'b0;
    chk("t3_empty", 32'(cnt), 0);
    // flush with a simultaneous push
    rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin push(32'h300 + 32'(4 * i), 7'b0010011); step(); end
    chk("t4_cnt5", 32'(cnt), 5);
    rob_full = 1'b0; flush = 1'b1; push(32'h3FC, 7'b0010011); #1;
    chk("t4_flush_de", 32'(de), 0);
    step();
    flush = 1'b0; fv = 1'b0; #1;
    chk("t4_cnt0", 32'(cnt), 0); chk("t4_de0", 32'(de), 0);
    push(32'h310, 7'b0010011); step();
    fv = 1'b0; #1;
    chk("t4_post_cnt", 32'(cnt), 1); chk("t4_post_pc", opc, 32'h310);
    step();
    // full queue: simultaneous push and pop
    rob_full = 1'b1;
    for (int i = 0; i < 16; i++) begin push(32'h400 + 32'(4 * i), 7'b0010011); step(); end
    chk("t5_cnt16", 32'(cnt), 16);
    rob_full = 1'b0; push(32'h4F0, 7'b0010011); #1;
    chk("t5_de", 32'(de), 1); chk("t5_pc_head", opc, 32'h400);
    step();
    fv = 1'b0; #1;
    chk("t5_cnt_hold", 32'(cnt), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5_pc%0d", i), opc, (i < 15) ? 32'h404 + 32'(4 * i) : 32'h4F0);
      step();
    end
    chk("t5_empty", 32'(cnt), 0);
    // rdy low freezes everything, including flush and push
    rob_full = 1'b1;
    push(32'h500, 7'b0010011); step();
    push(32'h504, 7'b0010011); step();
    rdy = 1'b0; flush = 1'b1; rob_full = 1'b0; push(32'h5FC, 7'b0010011);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t6_de%0d", i), 32'(de), 0);
      step();
      chk($sformatf("t6_cnt%0d", i), 32'(cnt), 2);
    end
    rdy = 1'b1; flush = 1'b0; fv = 1'b0; rob_full = 1'b1; #1;
    chk("t6_head_pc", opc, 32'h500);
`ifdef IQ_STALL_STAT_EN
    b_rob = s_rob; b_rs = s_rs; b_lsb = s_lsb;
    step(); step(); step();
    chk("t7_stall_rob", s_rob - b_rob, 3);
    chk("t7_stall_rs", s_rs - b_rs, 0);
    chk("t7_stall_lsb", s_lsb - b_lsb, 0);
`endif
    rob_full = 1'b0; #1;
    chk("t6_issue0", 32'(de), 1);
    step();
    chk("t6_pc1", opc, 32'h504);
    // reset overrides rdy low
    rdy = 1'b0; rst = 1'b1; step();
    rst = 1'b0; rdy = 1'b1; #1;
    chk("t8_reset_cnt", 32'(cnt), 0); chk("t8_reset_de", 32'(de), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
